// File: rtl/mul_add_pkg.sv
// Shared types and default widths for the shift-add multiply-accumulate block.
package mul_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  localparam int QW_DEF    = 8;
  localparam int DW_DEF    = 4;
  localparam int RW_DEF    = 5;
  localparam int CNT_W_DEF = (DW_DEF > 1) ? $clog2(DW_DEF) : 1;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage

// File: rtl/mul_add_8bit_seq.sv
// Sequential shift-add quotient*divisor + remainder; rebuilds a div_8bit dividend
// and flags (quotient, divisor, remainder) triples no valid division could produce.
module mul_add_8bit_seq
  import mul_add_pkg::*;
#(
  parameter  int QW = QW_DEF,
  parameter  int DW = DW_DEF,
  parameter  int RW = RW_DEF,
  localparam int PW = QW + DW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [QW-1:0] quotient_i,
  input  logic [DW-1:0] divisor_i,
  input  logic [RW-1:0] remainder_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [PW-1:0] product_o,
  output logic          bad_triple_o
);

  localparam int CW   = (DW > 1) ? $clog2(DW) : 1;
  localparam int CMPW = (RW > DW) ? RW : DW;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  state_e          state;
  state_e          state_nxt;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   mcand;
  logic [DW-1:0]   mplier;
  logic [CW-1:0]   cnt;
  logic            bad;
  logic            accept;

  // A remainder must be strictly below a non-zero divisor.
  function automatic logic is_bad(input logic [DW-1:0] d, input logic [RW-1:0] r);
    return (d == '0) || (CMPW'(r) >= CMPW'(d));
  endfunction

  assign accept = (state == IDLE) && in_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid_i)    state_nxt = CALC;
      CALC:    if (cnt == LAST)   state_nxt = DONE;
      DONE:    if (out_ready_i)   state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o   = 1'b0;
    out_valid_o  = 1'b0;
    product_o    = '0;
    bad_triple_o = 1'b0;
    unique case (state)
      IDLE: in_ready_o = 1'b1;
      DONE: begin
        out_valid_o  = 1'b1;
        product_o    = acc;
        bad_triple_o = bad;
      end
      default: ;
    endcase
  end

  // Always exactly DW iterations, even for a zero multiplier.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      bad    <= 1'b0;
    end else if (accept) begin
      acc    <= PW'(remainder_i);
      mcand  <= PW'(quotient_i);
      mplier <= divisor_i;
      cnt    <= '0;
      bad    <= is_bad(divisor_i, remainder_i);
    end else if (state == CALC) begin
      acc    <= acc + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_mul_add_8bit_seq.sv
// Bench for mul_add_8bit_seq: cycle-level reference model plus directed and round-trip vectors.
module tb_mul_add_8bit_seq;

  localparam int QW = 8;
  localparam int DW = 4;
  localparam int RW = 5;
  localparam int PW = QW + DW;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready_o;
  logic [QW-1:0] quotient;
  logic [DW-1:0] divisor;
  logic [RW-1:0] remainder;
  logic          out_valid_o;
  logic          out_ready;
  logic [PW-1:0] product_o;
  logic          bad_triple_o;

  int n_cmp = 0;
  int n_bad = 0;

  mul_add_8bit_seq #(.QW(QW), .DW(DW), .RW(RW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready_o),
    .quotient_i   (quotient),
    .divisor_i    (divisor),
    .remainder_i  (remainder),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready),
    .product_o    (product_o),
    .bad_triple_o (bad_triple_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight, result visible DW cycles after the
  // accept edge, held until consumed; updated on the negedge ahead of each active edge.
  logic          m_pend = 1'b0;
  int            m_lat  = 0;
  int            m_prod = 0;
  logic          m_bad  = 1'b0;
  logic          m_vld;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pend = 1'b0;
      m_lat  = 0;
      chk("rst in_ready", int'(in_ready_o), 1);
      chk("rst out_valid", int'(out_valid_o), 0);
      chk("rst product", int'(product_o), 0);
      chk("rst bad", int'(bad_triple_o), 0);
    end else begin
      if (m_pend) m_lat++;
      m_vld = m_pend && (m_lat > DW);
      chk("model in_ready", int'(in_ready_o), int'(!m_pend));
      chk("model out_valid", int'(out_valid_o), int'(m_vld));
      chk("model product", int'(product_o), m_vld ? m_prod : 0);
      chk("model bad", int'(bad_triple_o), m_vld ? int'(m_bad) : 0);
      if (m_vld && out_ready) begin
        m_pend = 1'b0;
      end else if (!m_pend && in_valid) begin
        m_pend = 1'b1;
        m_lat  = 0;
        m_prod = (int'(quotient) * int'(divisor) + int'(remainder)) % (1 << PW);
        m_bad  = (divisor == 0) || (int'(remainder) >= int'(divisor));
      end
    end
  end

  task automatic send(input logic [QW-1:0] q, input logic [DW-1:0] d, input logic [RW-1:0] r);
    int n = 0;
    @(posedge clk); #1;
    quotient  = q;
    divisor   = d;
    remainder = r;
    in_valid  = 1'b1;
    while (!in_ready_o && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready_o) chk("send timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [PW-1:0] p, output logic b);
    int n = 0;
    while (!out_valid_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid_o) chk("result timeout", 0, 1);
    p = product_o;
    b = bad_triple_o;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  logic [PW-1:0] p;
  logic          b;
  int            q_rt;
  int            r_rt;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    quotient  = '0;
    divisor   = '0;
    remainder = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", int'(in_ready_o), 1);
    chk("reset out_valid", int'(out_valid_o), 0);
    rst_n = 1'b1;

    send(8'd23, 4'd7, 5'd5);
    wait_result(p, b);
    chk("23*7+5", int'(p), 166);
    chk("23*7+5 bad", int'(b), 0);

    send(8'd255, 4'd15, 5'd31);
    wait_result(p, b);
    chk("255*15+31", int'(p), 3856);
    chk("255*15+31 bad", int'(b), 1);

    send(8'd100, 4'd0, 5'd9);
    wait_result(p, b);
    chk("d0 product", int'(p), 9);
    chk("d0 bad", int'(b), 1);

    // Stalled result, a stray pulse, then a held second triple.
    out_ready = 1'b0;
    send(8'd10, 4'd6, 5'd2);
    wait_result(p, b);
    chk("stall first", int'(p), 62);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin
        quotient = 8'd7; divisor = 4'd7; remainder = 5'd7; in_valid = 1'b1;
      end
      if (i == 3) in_valid = 1'b0;
      if (i == 6) begin
        quotient = 8'd3; divisor = 4'd4; remainder = 5'd2; in_valid = 1'b1;
      end
      chk("stall valid", int'(out_valid_o), 1);
      chk("stall product", int'(product_o), 62);
      chk("stall in_ready", int'(in_ready_o), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release out_valid", int'(out_valid_o), 0);
    chk("release in_ready", int'(in_ready_o), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(p, b);
    chk("second triple", int'(p), 14);
    chk("second bad", int'(b), 0);

    // Reset during the second CALC cycle.
    send(8'd200, 4'd9, 5'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", int'(out_valid_o), 0);
    chk("midrst product", int'(product_o), 0);
    chk("midrst in_ready", int'(in_ready_o), 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post-rst out_valid", int'(out_valid_o), 0);
    end
    send(8'd12, 4'd5, 5'd3);
    wait_result(p, b);
    chk("after reset", int'(p), 63);

    // Round trip through an integer division of every dividend/divisor pair.
    for (int dd = 0; dd < 256; dd++) begin
      for (int d = 1; d < 16; d++) begin
        q_rt = dd / d;
        r_rt = dd % d;
        send(QW'(q_rt), DW'(d), RW'(r_rt));
        wait_result(p, b);
        chk("roundtrip product", int'(p), dd);
        chk("roundtrip bad", int'(b), 0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      send(QW'(i * 85), 4'd0, RW'(i + 1));
      wait_result(p, b);
      chk("zero-div bad", int'(b), 1);
      chk("zero-div product", int'(p), i + 1);
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
